// File: rtl/hazard_mdctl.sv
// Pipeline hazard unit: forwarding, stall/flush generation and multiply/divide sequencing.
// Define HAZARD_PERF_EN to add the dstall/mdstall cycle counters.
module hazard_mdctl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              eretD,
  output logic              forwardaD,
  output logic              forwardbD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              md_startE,
  input  logic              md_is_divE,
  input  logic              excE,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              md_busy,
  output logic              md_done,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_dstall_cnt,
  output logic [31:0]       perf_mdstall_cnt,
`endif
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hitM_sD, hitM_tD, hitE_sD, hitE_tD;
  logic             lwstall, ctlstall, dstall, mdstall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (excE) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (md_startE) begin
          state <= RUN;
          cnt   <= md_is_divE ? DIV_LOAD : MUL_LOAD;
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign forwardaE = (rsE != '0 && rsE == writeregM && regwriteM) ? 2'b10 :
                     (rsE != '0 && rsE == writeregW && regwriteW) ? 2'b01 : 2'b00;
  assign forwardbE = (rtE != '0 && rtE == writeregM && regwriteM) ? 2'b10 :
                     (rtE != '0 && rtE == writeregW && regwriteW) ? 2'b01 : 2'b00;
  assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  assign hitE_sD = (writeregE != '0) && (writeregE == rsD);
  assign hitE_tD = (writeregE != '0) && (writeregE == rtD);
  assign hitM_sD = (writeregM != '0) && (writeregM == rsD);
  assign hitM_tD = (writeregM != '0) && (writeregM == rtD);

  assign lwstall  = memtoregE & (hitE_sD | hitE_tD);
  assign ctlstall = (branchD | jrD) &
                    ((regwriteE & (hitE_sD | hitE_tD)) | (memtoregM & (hitM_sD | hitM_tD)));
  assign dstall   = lwstall | ctlstall;

  // An exception abandons the mul/div, so it releases the stall in RUN as well as in IDLE.
  assign mdstall = ~excE & (((state == IDLE) & md_startE) | (state == RUN));

  assign md_busy = (state != IDLE);
  assign md_done = (state == DONE) & ~excE;

  assign stallW = mdstall;
  assign stallM = stallW;
  assign stallE = stallM;
  assign stallD = stallE | (dstall & ~flushD);
  assign stallF = stallD | (dstall & ~excE);

  assign flushF = 1'b0;
  assign flushW = 1'b0;
  assign flushD = (eretD & ~stallE) | excE;
  assign flushE = (dstall & ~mdstall) | excE;
  assign flushM = excE;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_dstall_cnt  <= '0;
      perf_mdstall_cnt <= '0;
    end else begin
      if (dstall & ~excE) perf_dstall_cnt  <= perf_dstall_cnt + 32'd1;
      if (mdstall)        perf_mdstall_cnt <= perf_mdstall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_mdctl.sv
// Directed-vector bench for hazard_mdctl with hand-computed expectations.
module tb_hazard_mdctl;

  localparam int REG_AW = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic resetn;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jrD, eretD, regwriteE, memtoregE, md_startE, md_is_divE, excE;
  logic regwriteM, memtoregM, regwriteW;
  logic forwardaD, forwardbD, md_busy, md_done;
  logic [1:0] forwardaE, forwardbE;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_dstall_cnt, perf_mdstall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_mdctl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD), .eretD(eretD),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .md_startE(md_startE), .md_is_divE(md_is_divE), .excE(excE),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .md_busy(md_busy), .md_done(md_done),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
`ifdef HAZARD_PERF_EN
    .perf_dstall_cnt(perf_dstall_cnt), .perf_mdstall_cnt(perf_mdstall_cnt),
`endif
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may then be changed, followed by #1 before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    branchD = 0; jrD = 0; eretD = 0; regwriteE = 0; memtoregE = 0;
    md_startE = 0; md_is_divE = 0; excE = 0;
    regwriteM = 0; memtoregM = 0; regwriteW = 0;
  endtask

  // Hold a mul/div in E, measure the stall length and confirm md_done lands right after it.
  task automatic run_md(input logic div, input int lat, input string tag);
    int n = 0;
    int early_done = 0;
    md_startE = 1; md_is_divE = div; #1;
    check({tag, "_busy_first"}, 32'(md_busy), 0);
    check({tag, "_stallF_first"}, 32'(stallF), 1);
    while (stallE && n < 200) begin
      if (md_done) early_done++;
      n++;
      tick;
    end
    check({tag, "_stall_len"}, n, lat);
    check({tag, "_done_early"}, early_done, 0);
    check({tag, "_done"}, 32'(md_done), 1);
    check({tag, "_busy_done"}, 32'(md_busy), 1);
    tick;
    md_startE = 0; #1;
    check({tag, "_busy_after"}, 32'(md_busy), 0);
    check({tag, "_done_after"}, 32'(md_done), 0);
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    #1;
    check("rst_busy", 32'(md_busy), 0);
    check("rst_done", 32'(md_done), 0);
    check("rst_stalls", 32'({stallF, stallD, stallE, stallM, stallW}), 0);
    check("rst_flushes", 32'({flushF, flushD, flushE, flushM, flushW}), 0);
    tick; tick;
    resetn = 1;
    tick;

    // Forwarding priority
    rsE = 3; rtE = 3; writeregM = 3; writeregW = 3; regwriteM = 1; regwriteW = 1; rsD = 3; #1;
    check("fwdaE_M", 32'(forwardaE), 2);
    check("fwdbE_M", 32'(forwardbE), 2);
    check("fwdaD_M", 32'(forwardaD), 1);
    regwriteM = 0; #1;
    check("fwdaE_W", 32'(forwardaE), 1);
    check("fwdbE_W", 32'(forwardbE), 1);
    check("fwdaD_none", 32'(forwardaD), 0);
    rsE = 0; #1;
    check("fwdaE_zero", 32'(forwardaE), 0);
    check("fwdbE_still_W", 32'(forwardbE), 1);
    clear_inputs(); tick;

    // Load-use
    memtoregE = 1; writeregE = 8; rtD = 8; #1;
    check("lw_stallF", 32'(stallF), 1);
    check("lw_stallD", 32'(stallD), 1);
    check("lw_flushE", 32'(flushE), 1);
    check("lw_stallE", 32'(stallE), 0);
    tick;
    memtoregE = 0; writeregE = 0; #1;
    check("lw_release", 32'({stallF, stallD, flushE}), 0);
    memtoregE = 1; writeregE = 0; rtD = 0; #1;
    check("lw_r0", 32'({stallF, stallD, flushE}), 0);
    clear_inputs(); tick;

    // Branch hazard on E then on a load in M
    branchD = 1; regwriteE = 1; writeregE = 4; rsD = 4; #1;
    check("br_E_stall", 32'({stallF, stallD, flushE}), 3'b111);
    tick;
    regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 4; #1;
    check("br_M_stall", 32'({stallF, stallD, flushE}), 3'b111);
    tick;
    memtoregM = 0; writeregM = 0; #1;
    check("br_release", 32'({stallF, stallD, flushE}), 0);
    clear_inputs(); tick;

    run_md(1'b0, MUL_LAT, "mul");
    tick;
    run_md(1'b1, DIV_LAT, "div");
    tick;

    // Exception at RUN with cnt==10
    md_startE = 1; md_is_divE = 1; #1;
    for (int i = 0; i < 22; i++) tick;
    check("abort_busy_before", 32'(md_busy), 1);
    excE = 1; #1;
    check("abort_flushDEM", 32'({flushD, flushE, flushM}), 3'b111);
    check("abort_stallF", 32'(stallF), 0);
    check("abort_stallE", 32'(stallE), 0);
    check("abort_done", 32'(md_done), 0);
    tick;
    excE = 0; md_startE = 0; #1;
    check("abort_busy_after", 32'(md_busy), 0);
    check("abort_done_after", 32'(md_done), 0);
    tick;
    check("abort_done_later", 32'(md_done), 0);

    // Exception coincident with acceptance in IDLE
    md_startE = 1; md_is_divE = 0; excE = 1; #1;
    check("exc_idle_stallE", 32'(stallE), 0);
    check("exc_idle_flushE", 32'(flushE), 1);
    tick;
    excE = 0; md_startE = 0; #1;
    check("exc_idle_busy", 32'(md_busy), 0);

    // Async reset mid-RUN
    md_startE = 1; md_is_divE = 1; #1;
    for (int i = 0; i < 5; i++) tick;
    check("rstrun_busy_before", 32'(md_busy), 1);
    md_startE = 0; resetn = 0; #1;
    check("rstrun_busy", 32'(md_busy), 0);
    check("rstrun_stallE", 32'(stallE), 0);
    tick;
    resetn = 1; tick;

    // ERET
    eretD = 1; #1;
    check("eret_flushD", 32'(flushD), 1);
    md_startE = 1; md_is_divE = 1; #1;
    check("eret_div_flushD", 32'(flushD), 0);
    for (int i = 0; i < 200 && stallE; i++) begin
      if (i == 15) check("eret_mid_flushD", 32'(flushD), 0);
      tick;
    end
    check("eret_done_flushD", 32'(flushD), 1);
    tick;
    clear_inputs(); #1;
    check("final_busy", 32'(md_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
